// File: rtl/jt51_fir_seq.sv
// FIR sequencer: writes each sample into a circular RAM delay line, then reads back TAPS samples for a MAC.
// Define JT51_FIR_SAT_EN to clamp the rounded output; otherwise it wraps to data_width bits.
module jt51_fir_seq #(
  parameter int data_width  = 16,
  parameter int addr_width  = 7,
  parameter int coeff_width = 16,
  parameter int TAPS        = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [data_width-1:0]  din,
  input  logic                          din_valid,
  output logic                          busy,
  output logic                          overrun,
  output logic signed [data_width-1:0]  dout,
  output logic                          dout_valid,
  output logic [data_width-1:0]         ram_data,
  output logic [addr_width-1:0]         ram_addr,
  output logic                          ram_we,
  input  logic signed [data_width-1:0]  ram_q,
  output logic [addr_width-1:0]         coeff_addr,
  input  logic signed [coeff_width-1:0] coeff_q
);

  localparam int PW = data_width + coeff_width;
  localparam int AW = PW + $clog2(TAPS);
  localparam logic [addr_width-1:0] LAST_TAP  = addr_width'(TAPS - 1);
  localparam logic [addr_width-1:0] LAST_ADDR = '1;
  localparam logic signed [AW:0] ROUND_BIAS = (AW + 1)'(1) << (coeff_width - 2);

  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, READ, FLUSH, DONE} state_t;

  state_t                        state_q, state_d;
  logic [addr_width-1:0]         wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0]         clr_cnt_q, clr_cnt_d;
  logic [addr_width-1:0]         tap_q, tap_d;
  logic signed [data_width-1:0]  din_q, din_d;
  logic signed [AW-1:0]          acc_q, acc_d;
  logic                          mac_q, mac_d;
  logic signed [data_width-1:0]  dout_q, dout_d;
  logic                          dout_valid_q, dout_valid_d;
  logic                          overrun_q, overrun_d;

  logic signed [PW-1:0]          prod;
  logic signed [AW:0]            rnd_sum;
  logic signed [AW:0]            rnd_shift;
  logic signed [data_width-1:0]  dout_res;

  assign prod      = PW'(ram_q) * PW'(coeff_q);
  assign rnd_sum   = {acc_q[AW-1], acc_q} + ROUND_BIAS;
  assign rnd_shift = rnd_sum >>> (coeff_width - 1);

`ifdef JT51_FIR_SAT_EN
  localparam logic signed [AW:0] SAT_MAX = (AW + 1)'((2 ** (data_width - 1)) - 1);
  localparam logic signed [AW:0] SAT_MIN = -SAT_MAX - (AW + 1)'(1);

  always_comb begin
    dout_res = data_width'(rnd_shift);
    if (rnd_shift > SAT_MAX) dout_res = data_width'(SAT_MAX);
    else if (rnd_shift < SAT_MIN) dout_res = data_width'(SAT_MIN);
  end
`else
  always_comb begin
    dout_res = data_width'(rnd_shift);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      wr_ptr_q     <= '0;
      clr_cnt_q    <= '0;
      tap_q        <= '0;
      din_q        <= '0;
      acc_q        <= '0;
      mac_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      clr_cnt_q    <= clr_cnt_d;
      tap_q        <= tap_d;
      din_q        <= din_d;
      acc_q        <= acc_d;
      mac_q        <= mac_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  // RAM/coeff data arrive one cycle after the address, so the MAC trails READ by a cycle
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    clr_cnt_d    = clr_cnt_q;
    tap_d        = tap_q;
    din_d        = din_q;
    acc_d        = acc_q;
    dout_d       = dout_q;
    mac_d        = (state_q == READ);
    dout_valid_d = (state_q == DONE);
    overrun_d    = din_valid && (state_q != IDLE);
    busy         = 1'b1;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_data     = '0;
    coeff_addr   = '0;

    if (mac_q) acc_d = acc_q + {{(AW - PW){prod[PW-1]}}, prod};

    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) state_d = IDLE;
      end
      IDLE: begin
        busy = 1'b0;
        if (din_valid) begin
          din_d   = din;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ram_we   = 1'b1;
        ram_addr = wr_ptr_q;
        ram_data = din_q;
        acc_d    = '0;
        tap_d    = '0;
        state_d  = READ;
      end
      READ: begin
        ram_addr   = wr_ptr_q - tap_q;
        coeff_addr = tap_q;
        tap_d      = tap_q + 1'b1;
        if (tap_q == LAST_TAP) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        dout_d   = dout_res;
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    if (rst) ram_we = 1'b0;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule
